mips_avalon_lsu: RTL and testbench
==================================

// Module: mips_avalon_lsu
// PURPOSE
//   Parametrised load/store unit between the multicycle MIPS core and the Avalon-MM bus.
//   Replaces direct read/write/address driving from the control FSM. Honours waitrequest
//   and supplies the core's stall. Generates byteenable and lane-shifted writedata for
//   SB/SH/SW, and sign/zero-extends LB/LBU/LH/LHU/LW data.
//   Little-endian; one outstanding transfer.
// PARAMETERS
//   ADDR_WIDTH  32  byte address width
//   DATA_WIDTH  32  bus data width; legal values 32 or 64; LANES = DATA_WIDTH/8
//   TIMEOUT     0   max waitrequest cycles before abort; 0 = wait forever
// PORTS
//   clk           in   1           rising-edge clock
//   reset         in   1           asynchronous, active-high reset
//   req_valid     in   1           core presents a load/store
//   req_ready     out  1           LSU can accept (IDLE only)
//   req_write     in   1           1 = store, 0 = load
//   req_size      in   2           00 byte, 01 half, 10 word; 11 is illegal (error)
//   req_unsigned  in   1           load zero-extends when 1
//   req_addr      in   ADDR_WIDTH  byte address
//   req_wdata     in   32          store data, right-justified
//   resp_valid    out  1           one-cycle completion pulse
//   resp_error    out  1           qualifies resp_valid: misaligned/illegal/timeout
//   resp_rdata    out  32          extended load data; 0 for stores and errors
//   stall         out  1           high from accept until resp_valid cycle (inclusive)
//   address       out  ADDR_WIDTH  req_addr with low log2(LANES) bits cleared
//   read          out  1           Avalon read
//   write         out  1           Avalon write
//   waitrequest   in   1           Avalon slave stall
//   writedata     out  DATA_WIDTH  lane-positioned store data
//   byteenable    out  LANES       active lanes
//   readdata      in   DATA_WIDTH  valid in the cycle read=1 and waitrequest=0
// BEHAVIOUR
//   - Reset values: all outputs 0 except req_ready=1. State = IDLE.
//   - Reset is asynchronous: read/write drop immediately, even mid-transfer.
//   - FSM: IDLE -> BUS on accept (req_valid & req_ready) with a legal request.
//     IDLE -> ERR on accept with a misaligned or illegal request.
//     BUS -> RESP when waitrequest=0. BUS -> ERR when the timeout expires.
//     RESP -> IDLE and ERR -> IDLE unconditionally.
//   - Misaligned: half with addr[0]=1; word with addr[1:0]!=0. No bus cycle is issued.
//   - Request fields are registered at accept. address, byteenable and writedata stay
//     stable throughout BUS.
//   - Lane select: lane = addr[log2(LANES)-1:0].
//     byteenable = {1,3,F}[size] << lane. writedata = data replicated across the bus.
//   - Load: extract (readdata >> 8*lane) as byte/half/word, then sign- or zero-extend.
//     Capture happens in the BUS cycle where waitrequest=0.
//   - Latency: accept at cycle N; read/write high from N+1; resp_valid at (last BUS
//     cycle)+1. Minimum is 2 cycles. ERR from IDLE gives resp_valid at N+1.
//   - Timeout: counter increments each BUS cycle with waitrequest=1. When it reaches
//     TIMEOUT, read/write drop next cycle and ERR is entered. Counter clears on accept.
//   - read and write are never high together.
//   - req_valid is ignored outside IDLE. A new request may be accepted in the cycle
//     after resp_valid.
// TESTING
//   1. SW 0xDEADBEEF @0x1000, waitrequest=0 -> write=1 for 1 cycle, be=1111,
//      writedata=DEADBEEF; resp_valid at cycle+2, resp_error=0.
//   2. LB @0x1003, readdata=0x80FF0000 -> be=1000, rdata=0xFFFFFF80;
//      same request with LBU -> 0x00000080.
//   3. LH @0x2002, waitrequest=1 for 3 cycles, readdata=0x80011234 -> read held 4 cycles,
//      address stable at 0x2000, rdata=0xFFFF8001, stall high throughout.
//   4. LW @0x1002 -> read never asserted; resp_valid+resp_error at next cycle; rdata=0.
//   5. TIMEOUT=8, waitrequest stuck at 1 -> read drops after 8 wait cycles;
//      resp_error=1; req_ready=1 after.
//   6. DATA_WIDTH=64: SB 0xAB @0x105 -> address 0x100, be=0x20, writedata byte5=0xAB.
//      Also: reset asserted mid-BUS -> read=0 immediately; req_ready=1.

Source files
------------

// File: rtl/mips_avalon_lsu.sv
// Load/store unit between the multicycle MIPS core and an Avalon-MM master port.
// One outstanding transfer; little-endian lane steering and load extension.
module mips_avalon_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    output logic                    resp_error,
    output logic [31:0]             resp_rdata,
    output logic                    stall,
    output logic [ADDR_WIDTH-1:0]   address,
    output logic                    read,
    output logic                    write,
    input  logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   writedata,
    output logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   readdata
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(LANES);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP, S_ERR} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LANES-1:0]        be_q, be_d;
    logic [DATA_WIDTH-1:0]   wd_q, wd_d;
    logic                    wr_q, uns_q;
    logic [1:0]              size_q;
    logic [LB-1:0]           lane_q, lane_d;
    logic [31:0]             rdata_q, ld_raw, ld_ext;
    logic [31:0]             tcnt_q;
    logic                    accept, misalign, bad;

    assign lane_d   = req_addr[LB-1:0];
    assign accept   = req_valid && (state_q == S_IDLE);
    assign misalign = (req_size == 2'b01 && req_addr[0]) ||
                      (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign bad      = misalign || (req_size == 2'b11);

    always_comb begin
        be_d = '0;
        wd_d = '0;
        case (req_size)
            2'b00: begin
                be_d = LANES'(1) << lane_d;
                wd_d = {LANES{req_wdata[7:0]}};
            end
            2'b01: begin
                be_d = LANES'(3) << lane_d;
                wd_d = {(LANES/2){req_wdata[15:0]}};
            end
            default: begin
                be_d = LANES'(15) << lane_d;
                wd_d = {(LANES/4){req_wdata}};
            end
        endcase
    end

    // Gather the four bytes starting at the request lane; wrap is harmless since
    // aligned accesses never reach past the top lane.
    always_comb begin
        ld_raw = '0;
        for (int i = 0; i < 4; i++)
            ld_raw[8*i +: 8] = readdata[8*((int'(lane_q) + i) % LANES) +: 8];
        case (size_q)
            2'b00:   ld_ext = {{24{~uns_q & ld_raw[7]}}, ld_raw[7:0]};
            2'b01:   ld_ext = {{16{~uns_q & ld_raw[15]}}, ld_raw[15:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = bad ? S_ERR : S_BUS;
            S_BUS: begin
                if (!waitrequest)
                    state_d = S_RESP;
                else if (TIMEOUT != 0 && tcnt_q == 32'(TIMEOUT - 1))
                    state_d = S_ERR;
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            wr_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            lane_q  <= '0;
            rdata_q <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= {req_addr[ADDR_WIDTH-1:LB], {LB{1'b0}}};
                be_q   <= be_d;
                wd_q   <= wd_d;
                wr_q   <= req_write;
                uns_q  <= req_unsigned;
                size_q <= req_size;
                lane_q <= lane_d;
                tcnt_q <= '0;
            end
            if (state_q == S_BUS) begin
                if (waitrequest)
                    tcnt_q <= tcnt_q + 32'd1;
                else
                    rdata_q <= wr_q ? 32'd0 : ld_ext;
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign read       = (state_q == S_BUS) && !wr_q;
    assign write      = (state_q == S_BUS) && wr_q;
    assign address    = addr_q;
    assign byteenable = be_q;
    assign writedata  = wd_q;
    assign resp_valid = (state_q == S_RESP) || (state_q == S_ERR);
    assign resp_error = (state_q == S_ERR);
    assign resp_rdata = (state_q == S_RESP) ? rdata_q : 32'd0;
    assign stall      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mips_avalon_lsu.sv
// Bench for mips_avalon_lsu: a 32-bit instance with an 8-cycle timeout and a
// 64-bit instance that waits forever, checked against a byte-lane reference model.
module tb_mips_avalon_lsu;
    localparam int TO = 8;

    logic        clk = 1'b0, reset = 1'b1;
    int          checks = 0, errors = 0;

    // 32-bit instance
    logic        req_valid = 0, req_ready, req_write = 0, req_unsigned = 0;
    logic [1:0]  req_size = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, resp_rdata, address, writedata, readdata = 0;
    logic        resp_valid, resp_error, stall, read, write, waitrequest = 0;
    logic [3:0]  byteenable;

    // 64-bit instance
    logic        b_req_valid = 0, b_req_ready, b_req_write = 0, b_req_unsigned = 0;
    logic [1:0]  b_req_size = 0;
    logic [31:0] b_req_addr = 0, b_req_wdata = 0, b_resp_rdata, b_address;
    logic        b_resp_valid, b_resp_error, b_stall, b_read, b_write, b_waitrequest = 0;
    logic [63:0] b_writedata, b_readdata = 0;
    logic [7:0]  b_byteenable;

    always #5 clk = ~clk;

    mips_avalon_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_error(resp_error), .resp_rdata(resp_rdata), .stall(stall),
        .address(address), .read(read), .write(write), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata));

    mips_avalon_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_size(b_req_size), .req_unsigned(b_req_unsigned),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .resp_valid(b_resp_valid),
        .resp_error(b_resp_error), .resp_rdata(b_resp_rdata), .stall(b_stall),
        .address(b_address), .read(b_read), .write(b_write), .waitrequest(b_waitrequest),
        .writedata(b_writedata), .byteenable(b_byteenable), .readdata(b_readdata));

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] ad, wd;
        int          waits;
        logic [31:0] rd;
        logic        perr;
        logic [3:0]  be;
        logic [31:0] ewd, erd;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: byte-count arithmetic over lanes, independent of any FSM view.
    function automatic void model(input logic wr, input logic [1:0] sz, input logic un,
                                  input logic [31:0] ad, input logic [31:0] wd,
                                  input logic [63:0] rd, input int lanes,
                                  output logic [7:0] be, output logic [63:0] wdo,
                                  output logic [31:0] rdo, output logic err);
        int nb, lane;
        logic [63:0] v, m;
        nb   = 1 << sz;
        lane = int'(ad[2:0]) % lanes;
        err  = (sz == 2'd3) || ((int'(ad[2:0]) % nb) != 0);
        be   = 8'(((1 << nb) - 1) << lane);
        wdo  = '0;
        for (int j = 0; j < lanes; j++)
            wdo[8*j +: 8] = 8'(wd >> (8 * (j % nb)));
        m = (nb >= 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        v = (rd >> (8 * lane)) & m;
        if (!un && v[8*nb-1]) v = v | ~m;
        rdo = (wr || err) ? 32'd0 : v[31:0];
    endfunction

    // One transaction on the 32-bit instance, starting at the first IDLE negedge.
    task automatic run_a(input logic wr, input logic [1:0] sz, input logic un,
                         input logic [31:0] ad, input logic [31:0] wd, input int waits,
                         input logic [31:0] rd, input logic perr, input logic [3:0] ebe,
                         input logic [31:0] ewd, input logic [31:0] erd);
        bit timed_out;
        int nbus;
        timed_out = (waits >= TO);
        @(negedge clk);
        chk("a_ready_idle", req_ready, 1);
        chk("a_stall_idle", stall, 0);
        chk("a_resp_idle", resp_valid, 0);
        req_valid = 1; req_write = wr; req_size = sz; req_unsigned = un;
        req_addr = ad; req_wdata = wd;
        @(negedge clk);
        // junk request while busy must be ignored
        req_valid = 1'($urandom_range(0, 1)); req_addr = $urandom; req_write = ~wr;
        req_size = 2'($urandom); req_wdata = $urandom;
        if (perr) begin
            chk("a_err_valid", resp_valid, 1);
            chk("a_err_flag", resp_error, 1);
            chk("a_err_rdata", resp_rdata, 0);
            chk("a_err_nobus", {read, write}, 0);
            chk("a_err_stall", stall, 1);
        end else begin
            nbus = timed_out ? TO : waits + 1;
            for (int c = 0; c < nbus; c++) begin
                waitrequest = (c < waits);
                readdata    = (c < waits) ? $urandom : rd;
                chk("a_read", read, !wr);
                chk("a_write", write, wr);
                chk("a_address", address, {ad[31:2], 2'b00});
                chk("a_be", byteenable, ebe);
                if (wr) chk("a_wdata", writedata, ewd);
                chk("a_stall_bus", stall, 1);
                chk("a_resp_bus", resp_valid, 0);
                if (c < nbus - 1) @(negedge clk);
            end
            @(negedge clk);
            waitrequest = 0;
            chk("a_resp_valid", resp_valid, 1);
            chk("a_resp_error", resp_error, timed_out);
            chk("a_resp_rdata", resp_rdata, timed_out ? 32'd0 : erd);
            chk("a_resp_nobus", {read, write}, 0);
            chk("a_stall_resp", stall, 1);
        end
        req_valid = 0;
    endtask

    task automatic run_b(input logic wr, input logic [1:0] sz, input logic un,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [63:0] rd);
        logic [7:0] be; logic [63:0] wdo; logic [31:0] rdo; logic perr;
        model(wr, sz, un, ad, wd, rd, 8, be, wdo, rdo, perr);
        @(negedge clk);
        chk("b_ready_idle", b_req_ready, 1);
        b_req_valid = 1; b_req_write = wr; b_req_size = sz; b_req_unsigned = un;
        b_req_addr = ad; b_req_wdata = wd; b_waitrequest = 0; b_readdata = rd;
        @(negedge clk);
        b_req_valid = 0;
        if (perr) begin
            chk("b_err_valid", b_resp_valid, 1);
            chk("b_err_flag", b_resp_error, 1);
            chk("b_err_nobus", {b_read, b_write}, 0);
        end else begin
            chk("b_address", b_address, {ad[31:3], 3'b000});
            chk("b_be", b_byteenable, be);
            chk("b_rw", {b_read, b_write}, {!wr, wr});
            if (wr) chk("b_wdata", b_writedata, wdo);
            @(negedge clk);
            chk("b_resp_valid", b_resp_valid, 1);
            chk("b_resp_error", b_resp_error, 0);
            chk("b_resp_rdata", b_resp_rdata, rdo);
        end
    endtask

    initial begin
        logic [7:0] mbe; logic [63:0] mwd; logic [31:0] mrd; logic mperr;
        logic wr, un; logic [1:0] sz; logic [31:0] ad, wd, rd; int waits;

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEADBEEF, 0, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 32'h1003, 32'h0,        0, 32'h80FF0000, 1'b0, 4'h8, 32'h0, 32'hFFFFFF80};
        tbl[2]  = '{1'b0, 2'd0, 1'b1, 32'h1003, 32'h0,        0, 32'h80FF0000, 1'b0, 4'h8, 32'h0, 32'h00000080};
        tbl[3]  = '{1'b0, 2'd1, 1'b0, 32'h2002, 32'h0,        3, 32'h80011234, 1'b0, 4'hC, 32'h0, 32'hFFFF8001};
        tbl[4]  = '{1'b0, 2'd2, 1'b0, 32'h1002, 32'h0,        0, 32'h0,        1'b1, 4'h0, 32'h0, 32'h0};
        tbl[5]  = '{1'b0, 2'd2, 1'b0, 32'h3000, 32'h0,       20, 32'h12345678, 1'b0, 4'hF, 32'h0, 32'h0};
        tbl[6]  = '{1'b1, 2'd1, 1'b0, 32'h2002, 32'h1234ABCD, 1, 32'h0,        1'b0, 4'hC, 32'hABCDABCD, 32'h0};
        tbl[7]  = '{1'b1, 2'd0, 1'b0, 32'h1001, 32'hFFFFFF5A, 0, 32'h0,        1'b0, 4'h2, 32'h5A5A5A5A, 32'h0};
        tbl[8]  = '{1'b0, 2'd3, 1'b0, 32'h0000, 32'h0,        0, 32'h0,        1'b1, 4'h0, 32'h0, 32'h0};
        tbl[9]  = '{1'b0, 2'd1, 1'b1, 32'h2000, 32'h0,        1, 32'h7777F00D, 1'b0, 4'h3, 32'h0, 32'h0000F00D};
        tbl[10] = '{1'b0, 2'd1, 1'b0, 32'h2001, 32'h0,        0, 32'h0,        1'b1, 4'h0, 32'h0, 32'h0};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h0040, 32'h0,        2, 32'h87654321, 1'b0, 4'hF, 32'h0, 32'h87654321};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h0044, 32'h0,        7, 32'h0BADF00D, 1'b0, 4'hF, 32'h0, 32'h0BADF00D};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 32'h1002, 32'h0,        0, 32'h00127F00, 1'b0, 4'h4, 32'h0, 32'h00000012};

        #2;
        chk("rst_ready", req_ready, 1);
        chk("rst_rw", {read, write}, 0);
        chk("rst_resp", {resp_valid, resp_error}, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_addr", address, 0);
        chk("rst_be", byteenable, 0);
        chk("rst_wdata", writedata, 0);
        chk("rst_b_ready", b_req_ready, 1);
        chk("rst_b_wdata", b_writedata, 0);
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 14; i++)
            run_a(tbl[i].wr, tbl[i].sz, tbl[i].un, tbl[i].ad, tbl[i].wd, tbl[i].waits,
                  tbl[i].rd, tbl[i].perr, tbl[i].be, tbl[i].ewd, tbl[i].erd);

        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom_range(0, 1)); un = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3)); ad = $urandom & 32'h0000FFFF;
            wd = $urandom; rd = $urandom;
            waits = ($urandom_range(0, 9) == 0) ? 8 + $urandom_range(0, 3) : $urandom_range(0, 3);
            model(wr, sz, un, ad, wd, {32'd0, rd}, 4, mbe, mwd, mrd, mperr);
            run_a(wr, sz, un, ad, wd, waits, rd, mperr, mbe[3:0], mwd[31:0], mrd);
        end

        run_b(1'b1, 2'd0, 1'b0, 32'h105, 32'h000000AB, 64'h0);
        chk("b_sb_byte5", b_writedata[47:40], 8'hAB);
        run_b(1'b0, 2'd2, 1'b0, 32'h10C, 32'h0, 64'h1122334455667788);
        run_b(1'b0, 2'd1, 1'b0, 32'h10E, 32'h0, 64'h1122334455667788);
        run_b(1'b0, 2'd0, 1'b0, 32'h107, 32'h0, 64'h8022334455667788);
        run_b(1'b1, 2'd2, 1'b0, 32'h104, 32'hCAFEF00D, 64'h0);
        run_b(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 64'h0);

        // asynchronous reset in the middle of a stalled transfer
        @(negedge clk);
        req_valid = 1; req_write = 0; req_size = 2'd2; req_addr = 32'h500; waitrequest = 1;
        b_req_valid = 1; b_req_write = 1; b_req_size = 2'd0; b_req_addr = 32'h105; b_waitrequest = 1;
        @(negedge clk);
        req_valid = 0; b_req_valid = 0;
        chk("mid_read", read, 1);
        chk("mid_b_write", b_write, 1);
        #2 reset = 1;
        #1;
        chk("async_read", read, 0);
        chk("async_ready", req_ready, 1);
        chk("async_stall", stall, 0);
        chk("async_b_write", b_write, 0);
        chk("async_b_ready", b_req_ready, 1);
        @(negedge clk);
        reset = 0; waitrequest = 0; b_waitrequest = 0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_resp", resp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
